// File: rtl/rng_harvest_ctrl.sv
// rng_harvest_ctrl: sequences the ring-oscillator entropy source.
// Releases the ring, waits out a warm-up period, samples the XOR-folded
// ring taps at a programmable interval, packs 32 bits per word into a
// small FIFO, and shuts the ring down when a repetition-count health test
// detects a stuck source.
module rng_harvest_ctrl #(
    parameter int NTAPS      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_LIMIT  = 32
) (
    input  logic             clk,
    input  logic             reset_global,
    input  logic             start,
    input  logic [15:0]      warmup_cycles,
    input  logic [15:0]      sample_period,
    input  logic [NTAPS-1:0] ring_taps,
    input  logic             rd_ready,
    output logic             ring_reset,
    output logic [31:0]      word_out,
    output logic             word_valid,
    output logic [2:0]       fifo_level,
    output logic             health_fail,
    output logic [2:0]       state,
    output logic [31:0]      words_total
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(RCT_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_HARVEST = 3'd2,
        ST_STALL   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;

    logic [NTAPS-1:0]  sync1;
    logic [NTAPS-1:0]  sync2;
    logic              sample_bit;

    logic [15:0]       warm_cnt;
    logic [15:0]       period_cnt;
    logic [15:0]       period_last;
    logic              tick;

    logic [31:0]       shift_reg;
    logic [4:0]        bit_cnt;
    logic [31:0]       full_word;
    logic              word_done;

    logic [RW-1:0]     rct_cnt;
    logic [RW-1:0]     rct_next;
    logic              prev_bit;
    logic              rct_trip;

    logic [31:0]       mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       level;
    logic              fifo_full;
    logic              pop;
    logic              space;
    logic              push;
    logic [31:0]       push_data;

    assign sample_bit  = ^sync2;
    assign period_last = (sample_period == 16'd0) ? 16'd0 : sample_period - 16'd1;
    assign tick        = (cur_state == ST_HARVEST) && (period_cnt >= period_last);
    assign full_word   = {shift_reg[30:0], sample_bit};
    assign word_done   = tick && (bit_cnt == 5'd31);
    assign rct_next    = ((rct_cnt == '0) || (sample_bit != prev_bit)) ? RW'(1) : rct_cnt + RW'(1);
    assign rct_trip    = tick && (rct_next == RW'(RCT_LIMIT));

    assign level       = wr_ptr - rd_ptr;
    assign fifo_full   = (level == (AW+1)'(FIFO_DEPTH));
    assign word_valid  = (level != '0);
    assign pop         = word_valid && rd_ready;
    assign space       = !fifo_full || pop;
    assign fifo_level  = 3'(level);
    assign word_out    = word_valid ? mem[rd_ptr[AW-1:0]] : 32'd0;

    assign state       = cur_state;
    assign ring_reset  = !(cur_state inside {ST_WARMUP, ST_HARVEST, ST_STALL});
    assign health_fail = (cur_state == ST_FAULT);

    // Two-flop synchronizer bringing the free-running ring taps into clk.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ring_taps;
            sync2 <= sync1;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) cur_state <= ST_IDLE;
        else              cur_state <= nxt_state;
    end

    // Next-state logic; a deasserted start always wins, a health trip beats word completion.
    always_comb begin
        nxt_state = cur_state;
        push      = 1'b0;
        push_data = shift_reg;
        case (cur_state)
            ST_IDLE: begin
                if (start) nxt_state = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!start)                          nxt_state = ST_IDLE;
                else if (warm_cnt >= warmup_cycles)  nxt_state = ST_HARVEST;
            end
            ST_HARVEST: begin
                if (!start) begin
                    nxt_state = ST_IDLE;
                end else if (rct_trip) begin
                    nxt_state = ST_FAULT;
                end else if (word_done) begin
                    if (space) begin
                        push      = 1'b1;
                        push_data = full_word;
                    end else begin
                        nxt_state = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!start) begin
                    nxt_state = ST_IDLE;
                end else if (space) begin
                    push      = 1'b1;
                    push_data = shift_reg;
                    nxt_state = ST_HARVEST;
                end
            end
            ST_FAULT: begin
                if (!start) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Warm-up and sample-period counters; the period counter freezes while stalled.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            warm_cnt   <= '0;
            period_cnt <= '0;
        end else begin
            warm_cnt <= (cur_state == ST_WARMUP) ? warm_cnt + 16'd1 : 16'd0;
            if (cur_state == ST_WARMUP)       period_cnt <= '0;
            else if (cur_state == ST_HARVEST) period_cnt <= tick ? 16'd0 : period_cnt + 16'd1;
        end
    end

    // Bit packing; a word that cannot be pushed stays parked in the shift register.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if ((cur_state == ST_WARMUP) || (nxt_state == ST_IDLE) || (nxt_state == ST_FAULT)) begin
            bit_cnt   <= '0;
        end else if (tick) begin
            shift_reg <= full_word;
            bit_cnt   <= bit_cnt + 5'd1;
        end
    end

    // Repetition-count health test over successive sampled bits.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            rct_cnt  <= '0;
            prev_bit <= 1'b0;
        end else if (cur_state == ST_WARMUP) begin
            rct_cnt  <= '0;
            prev_bit <= 1'b0;
        end else if (tick) begin
            rct_cnt  <= rct_next;
            prev_bit <= sample_bit;
        end
    end

    // Output word FIFO and running push count.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            words_total <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
                words_total         <= words_total + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_rng_harvest_ctrl.sv
// Bench for rng_harvest_ctrl: directed scenarios with literal expectations,
// followed by a long randomized run, all checked every cycle against a
// behavioural model built from bit queues and a word queue.
module tb_rng_harvest_ctrl;

    localparam int NTAPS = 32;
    localparam int DEPTH = 4;
    localparam int RCT   = 32;

    logic             clk = 1'b0;
    logic             reset_global;
    logic             start;
    logic [15:0]      warmup_cycles;
    logic [15:0]      sample_period;
    logic [NTAPS-1:0] ring_taps;
    logic             rd_ready;
    logic             ring_reset;
    logic [31:0]      word_out;
    logic             word_valid;
    logic [2:0]       fifo_level;
    logic             health_fail;
    logic [2:0]       state;
    logic [31:0]      words_total;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    int          m_state;
    int          m_wcnt;
    int          m_cd;
    int          m_run;
    bit          m_last;
    bit          m_s1;
    bit          m_s2;
    bit          m_bits[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_total;

    rng_harvest_ctrl #(.NTAPS(NTAPS), .FIFO_DEPTH(DEPTH), .RCT_LIMIT(RCT)) dut (
        .clk           (clk),
        .reset_global  (reset_global),
        .start         (start),
        .warmup_cycles (warmup_cycles),
        .sample_period (sample_period),
        .ring_taps     (ring_taps),
        .rd_ready      (rd_ready),
        .ring_reset    (ring_reset),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .fifo_level    (fifo_level),
        .health_fail   (health_fail),
        .state         (state),
        .words_total   (words_total)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison, counted and reported.
    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("[TB] FAIL cyc=%0d %s: got 0x%0h expected 0x%0h", cyc, name, got, exp);
        end
    endtask

    // Random tap vector whose XOR fold equals the requested bit.
    task automatic makeTaps(input bit want);
        logic [NTAPS-1:0] v;
        v = NTAPS'($urandom);
        if ((^v) != want) v[0] = ~v[0];
        ring_taps = v;
    endtask

    function automatic logic [31:0] packBits();
        logic [31:0] w;
        w = '0;
        foreach (m_bits[i]) w = {w[30:0], m_bits[i]};
        return w;
    endfunction

    // Advance the reference model across one clock edge using the driven inputs.
    task automatic modelStep();
        bit          b;
        bit          pop;
        bit          space;
        bit          do_push;
        logic [31:0] pw;
        int          p;
        if (reset_global) begin
            m_state = 0; m_wcnt = 0; m_cd = 0; m_run = 0; m_last = 0;
            m_s1 = 0; m_s2 = 0; m_total = 0;
            m_bits.delete();
            m_fifo.delete();
            return;
        end
        b       = m_s2;
        pop     = (m_fifo.size() > 0) && rd_ready;
        space   = (m_fifo.size() < DEPTH) || pop;
        do_push = 0;
        pw      = '0;
        p       = (sample_period == 16'd0) ? 1 : int'(sample_period);
        case (m_state)
            0: if (start) begin m_state = 1; m_wcnt = 0; end
            1: begin
                if (!start) m_state = 0;
                else if (m_wcnt >= int'(warmup_cycles)) begin
                    m_state = 2; m_cd = p; m_run = 0; m_bits.delete();
                end else m_wcnt++;
            end
            2: begin
                if (!start) begin
                    m_state = 0; m_bits.delete();
                end else begin
                    m_cd--;
                    if (m_cd == 0) begin
                        m_cd   = p;
                        m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
                        m_last = b;
                        m_bits.push_back(b);
                        if (m_run == RCT) begin
                            m_state = 4; m_bits.delete();
                        end else if (m_bits.size() == 32) begin
                            if (space) begin
                                do_push = 1; pw = packBits(); m_bits.delete();
                            end else m_state = 3;
                        end
                    end
                end
            end
            3: begin
                if (!start) begin
                    m_state = 0; m_bits.delete();
                end else if (space) begin
                    do_push = 1; pw = packBits(); m_bits.delete(); m_state = 2;
                end
            end
            4: if (!start) m_state = 0;
            default: m_state = 0;
        endcase
        if (pop) void'(m_fifo.pop_front());
        if (do_push) begin
            m_fifo.push_back(pw);
            m_total = m_total + 32'd1;
        end
        m_s2 = m_s1;
        m_s1 = ^ring_taps;
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        cmp("state",       32'(state),       32'(m_state));
        cmp("ring_reset",  32'(ring_reset),  32'(!(m_state inside {1, 2, 3})));
        cmp("health_fail", 32'(health_fail), 32'(m_state == 4));
        cmp("word_valid",  32'(word_valid),  32'(m_fifo.size() > 0));
        cmp("fifo_level",  32'(fifo_level),  32'(m_fifo.size()));
        cmp("word_out",    word_out,         (m_fifo.size() > 0) ? m_fifo[0] : 32'd0);
        cmp("words_total", words_total,      m_total);
    endtask

    // One clock: advance the model with the inputs already driven, then check after the edge.
    task automatic applyStimulus();
        modelStep();
        @(negedge clk);
        cyc++;
        checkOutput();
    endtask

    task automatic doReset();
        reset_global = 1'b1;
        start        = 1'b0;
        rd_ready     = 1'b0;
        applyStimulus();
        reset_global = 1'b0;
        cmp("rst_state",  32'(state),      32'd0);
        cmp("rst_ring",   32'(ring_reset), 32'd1);
        cmp("rst_valid",  32'(word_valid), 32'd0);
        cmp("rst_level",  32'(fifo_level), 32'd0);
        cmp("rst_total",  words_total,     32'd0);
        cmp("rst_word",   word_out,        32'd0);
        cmp("rst_health", 32'(health_fail), 32'd0);
    endtask

    // Start with warmup 0, period 1 and an alternating source whose first sample is 'first'.
    task automatic runAlt(input bit first, input int steps, input bit do_start);
        for (int m = 0; m < steps; m++) begin
            if (do_start && m == 0) start = 1'b1;
            makeTaps(first ^ bit'(m % 2));
            applyStimulus();
        end
    endtask

    initial begin
        int stuck_left;
        bit stuck_val;
        int ready_pct;

        reset_global  = 1'b1;
        start         = 1'b0;
        rd_ready      = 1'b0;
        warmup_cycles = 16'd0;
        sample_period = 16'd1;
        ring_taps     = '0;
        doReset();

        $display("[TB] warm-up and first word timing");
        warmup_cycles = 16'd5;
        sample_period = 16'd3;
        start = 1'b1;
        makeTaps(1'b1);
        applyStimulus();
        cmp("s1_ring_release", 32'(ring_reset), 32'd0);
        cmp("s1_warmup",       32'(state),      32'd1);
        for (int k = 1; k <= 5; k++) begin
            makeTaps(bit'((k + 1) % 2));
            applyStimulus();
        end
        cmp("s1_still_warmup", 32'(state), 32'd1);
        makeTaps(1'b1);
        applyStimulus();
        cmp("s1_harvest", 32'(state), 32'd2);
        for (int k = 7; k <= 101; k++) begin
            makeTaps(bit'((k + 1) % 2));
            applyStimulus();
        end
        cmp("s1_no_word_yet", 32'(word_valid), 32'd0);
        makeTaps(1'b0);
        applyStimulus();
        cmp("s1_word_valid", 32'(word_valid), 32'd1);
        cmp("s1_total",      words_total,     32'd1);

        $display("[TB] alternating source and FIFO stall");
        doReset();
        warmup_cycles = 16'd0;
        sample_period = 16'd1;
        runAlt(1'b1, 33, 1'b1);
        cmp("s2_no_word_yet", 32'(word_valid), 32'd0);
        makeTaps(1'b0);
        applyStimulus();
        cmp("s2_word_valid", 32'(word_valid), 32'd1);
        cmp("s2_word",       word_out,        32'hAAAAAAAA);
        cmp("s2_health",     32'(health_fail), 32'd0);
        for (int m = 34; m <= 165; m++) begin
            makeTaps(bit'((m + 1) % 2));
            applyStimulus();
        end
        cmp("s2_full",  32'(fifo_level), 32'd4);
        cmp("s2_stall", 32'(state),      32'd3);
        rd_ready = 1'b1;
        makeTaps(1'b0);
        applyStimulus();
        rd_ready = 1'b0;
        cmp("s2_level_kept", 32'(fifo_level), 32'd4);
        cmp("s2_resume",     32'(state),      32'd2);
        cmp("s2_total",      words_total,     32'd5);

        $display("[TB] stuck source health test");
        doReset();
        for (int m = 0; m <= 32; m++) begin
            start = 1'b1;
            makeTaps(1'b1);
            applyStimulus();
        end
        cmp("s3_pre_fault", 32'(state), 32'd2);
        makeTaps(1'b1);
        applyStimulus();
        cmp("s3_fault",  32'(state),       32'd4);
        cmp("s3_health", 32'(health_fail), 32'd1);
        cmp("s3_ring",   32'(ring_reset),  32'd1);
        cmp("s3_total",  words_total,      32'd0);
        start = 1'b0;
        applyStimulus();
        cmp("s3_idle",         32'(state),       32'd0);
        cmp("s3_health_clear", 32'(health_fail), 32'd0);

        $display("[TB] stop mid-word with words buffered");
        doReset();
        runAlt(1'b1, 83, 1'b1);
        start = 1'b0;
        applyStimulus();
        cmp("s4_idle",  32'(state),      32'd0);
        cmp("s4_level", 32'(fifo_level), 32'd2);
        cmp("s4_word0", word_out,        32'hAAAAAAAA);
        rd_ready = 1'b1;
        applyStimulus();
        cmp("s4_word1", word_out,        32'hAAAAAAAA);
        applyStimulus();
        cmp("s4_empty", 32'(word_valid), 32'd0);
        rd_ready = 1'b0;
        runAlt(1'b0, 34, 1'b1);
        cmp("s4_fresh_valid", 32'(fifo_level), 32'd1);
        cmp("s4_fresh_word",  word_out,        32'h55555555);

        $display("[TB] zero sample period and mid-run reset");
        doReset();
        sample_period = 16'd0;
        runAlt(1'b1, 33, 1'b1);
        cmp("s5_no_word_yet", 32'(word_valid), 32'd0);
        makeTaps(1'b0);
        applyStimulus();
        cmp("s5_word_valid", 32'(word_valid), 32'd1);
        runAlt(1'b1, 6, 1'b0);
        doReset();

        $display("[TB] randomized run");
        stuck_left = 0;
        stuck_val  = 1'b0;
        ready_pct  = 30;
        warmup_cycles = 16'd2;
        sample_period = 16'd1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) start = ~start;
            if (!start && $urandom_range(0, 3) == 0) begin
                warmup_cycles = 16'($urandom_range(0, 6));
                sample_period = 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 299) == 0) ready_pct = $urandom_range(0, 100);
            rd_ready = ($urandom_range(0, 99) < ready_pct);
            if (stuck_left == 0 && $urandom_range(0, 599) == 0) begin
                stuck_left = 150;
                stuck_val  = bit'($urandom_range(0, 1));
            end
            if (stuck_left > 0) begin
                stuck_left--;
                makeTaps(stuck_val);
            end else begin
                makeTaps(bit'($urandom_range(0, 1)));
            end
            reset_global = ($urandom_range(0, 1499) == 0);
            applyStimulus();
            reset_global = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rng_harvest_ctrl.md
Name: rng_harvest_ctrl

Overview:
- Sequences the ring-oscillator entropy chain (fastspk ring stages) on clk1.
- Releases the ring reset, waits out a warm-up period, then samples the ring taps at a programmable interval.
- Each sample is XOR-folded to one bit; 32 bits are packed into a word and buffered in a 4-deep FIFO for the host pipe-out.
- A repetition-count health test shuts the ring down on a stuck source.

Parameters:
- NTAPS, 32, number of asynchronous ring tap inputs.
- FIFO_DEPTH, 4, output word FIFO depth (power of 2).
- RCT_LIMIT, 32, identical consecutive sampled bits that trigger FAULT.

Ports:
- clk  in  1  system clock (clk1).
- reset_global  in  1  reset, asynchronous, active-high.
- start  in  1  level enable from host wire-in.
- warmup_cycles  in  16  clk cycles to hold in WARMUP after ring release.
- sample_period  in  16  clk cycles between samples; 0 is treated as 1.
- ring_taps  in  NTAPS  asynchronous ring oscillator outputs.
- rd_ready  in  1  consumer accepts the head word.
- ring_reset  out  1  drives the reset of ring stage 0; high means ring held.
- word_out  out  32  FIFO head word.
- word_valid  out  1  FIFO not empty.
- fifo_level  out  3  words in FIFO, 0..FIFO_DEPTH.
- health_fail  out  1  sticky stuck-source flag.
- state  out  3  IDLE=0, WARMUP=1, HARVEST=2, STALL=3, FAULT=4.
- words_total  out  32  count of words pushed, wraps at 2^32.

Behaviour:
- Reset values: ring_reset=1, word_out=0, word_valid=0, fifo_level=0, health_fail=0, state=IDLE, words_total=0. Synchronizer, shift register, bit counter, period counter, RCT counter and FIFO pointers are all cleared.
- ring_taps pass through a 2-FF synchronizer per bit. The sample bit is the XOR reduction of the synchronized taps.
- IDLE:
  - ring_reset=1.
  - start=1 -> WARMUP; warm-up counter loads 0.
- WARMUP:
  - ring_reset=0; counter increments each cycle.
  - When counter == warmup_cycles -> HARVEST. warmup_cycles=0 gives 1 cycle in WARMUP.
- HARVEST:
  - Period counter counts 0..P-1, where P = max(sample_period, 1). A tick fires when the counter equals P-1, then the counter wraps to 0. The first tick occurs P cycles after entry.
  - On each tick: shift <= {shift[30:0], bit}; bitcnt++.
  - On the tick where bitcnt reaches 32, the word is complete:
    - FIFO not full, or pop in the same cycle: push on that clock edge; word_valid is visible the next cycle; bitcnt=0.
    - Otherwise -> STALL, holding the word.
- STALL:
  - Ring keeps running; ticks are suppressed; period counter holds.
  - The held word is pushed on the first cycle the FIFO has space, including a same-cycle pop -> HARVEST. The period counter resumes from its held value.
- Health test:
  - On each tick, if bit == previous sampled bit, RCT counter++; else RCT counter=1.
  - When the counter reaches RCT_LIMIT: -> FAULT, health_fail=1, partial word discarded.
  - RCT history clears on entry to HARVEST from WARMUP.
- FAULT:
  - ring_reset=1; health_fail stays 1.
  - start=0 -> IDLE, health_fail cleared.
- start=0 in WARMUP, HARVEST or STALL: -> IDLE next cycle, ring_reset=1. The partial or held word is discarded. FIFO contents are retained and remain readable.
- FIFO:
  - Pop occurs when word_valid & rd_ready; word_out updates the next cycle.
  - Simultaneous push and pop when full is allowed; level is unchanged.
  - Pop when empty is ignored.
  - words_total increments on every push.
- Asserting reset_global mid-operation returns everything to reset values immediately, including FIFO contents.

Test Plan:
- Reset, start=1, warmup_cycles=5, sample_period=3, taps toggling one-hot pattern -> ring_reset falls 1 cycle after start. HARVEST entered 6 cycles later. First word valid 96+1 cycles after HARVEST entry; words_total=1.
- Drive synchronized taps so the XOR bit alternates 1,0,... -> word_out=32'hAAAAAAAA. health_fail stays 0.
- Taps constant (XOR=1), sample_period=1 -> FAULT entered on the 32nd tick, health_fail=1, ring_reset=1, no word pushed. start=0 -> IDLE, health_fail=0.
- rd_ready=0, alternating source -> 4 words fill the FIFO, fifo_level=4, then state=STALL. Assert rd_ready for 1 cycle -> held word pushed the same cycle, fifo_level stays 4, state=HARVEST.
- Deassert start mid-word (bitcnt=17) with 2 words in FIFO -> IDLE, fifo_level=2, both words readable. Restart -> the next word contains only new bits.
- sample_period=0 -> a tick every cycle; word completes 32 cycles after HARVEST entry. Assert reset_global mid-HARVEST -> all outputs at reset values the next sampled cycle.
